// File: rtl/alu_sequencer_pkg.sv
// Instruction set shared by the ALU sequencer, its ALU and its request/response interface.
package InstructionSetPkg;

  localparam int unsigned DataWidth                = 16;
  localparam int unsigned ImmediateWidth           = 8;
  localparam int unsigned DefaultMultiCycleLatency = 4;

  // Encodings 4'hE and 4'hF are intentionally undefined and complete as no-ops.
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    ADC  = 4'd1,
    SUB  = 4'd2,
    AND  = 4'd3,
    OR   = 4'd4,
    XOR  = 4'd5,
    NAND = 4'd6,
    ROL  = 4'd7,
    ROR  = 4'd8,
    ADDI = 4'd9,
    MUL  = 4'd10,
    MUH  = 4'd11,
    DIV  = 4'd12,
    MOD  = 4'd13
  } eOperation;

  typedef struct packed {
    logic Carry;
    logic Zero;
    logic Negative;
    logic Overflow;
    logic Parity;
  } sFlags;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT,
    DONE
  } eSeqState;

  function automatic logic IsMultiCycle(input eOperation op);
    return op inside {MUL, MUH, DIV, MOD};
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between an instruction source and the ALU sequencer.
interface alu_sequencer_if;
  import InstructionSetPkg::*;

  logic                      ReqValid;
  logic                      ReqReady;
  eOperation                 ReqOp;
  logic [ImmediateWidth-1:0] ReqImm;
  logic [DataWidth-1:0]      ReqSrc;
  logic [DataWidth-1:0]      ReqDest;
  logic                      RspValid;
  logic                      RspReady;
  logic [DataWidth-1:0]      RspDest;

  modport master (
    output ReqValid, ReqOp, ReqImm, ReqSrc, ReqDest, RspReady,
    input  ReqReady, RspValid, RspDest
  );

  modport slave (
    input  ReqValid, ReqOp, ReqImm, ReqSrc, ReqDest, RspReady,
    output ReqReady, RspValid, RspDest
  );

endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU: Result = Dest <op> Src (or Imm), flags derived from Result; undefined ops pass flags through.
module ArithmeticLogicUnit
  import InstructionSetPkg::*;
(
  input  eOperation                 Op,
  input  logic [ImmediateWidth-1:0] Imm,
  input  logic [DataWidth-1:0]      Src,
  input  logic [DataWidth-1:0]      Dest,
  input  sFlags                     FlagsIn,
  output logic [DataWidth-1:0]      Result,
  output sFlags                     FlagsOut
);

  localparam int unsigned Msb = DataWidth - 1;

  logic [DataWidth-1:0]          imm_ext;
  logic signed [2*DataWidth-1:0] prod;
  logic                          carry;
  logic                          ovf;
  logic                          defined;

  assign imm_ext = {{(DataWidth - ImmediateWidth){Imm[ImmediateWidth-1]}}, Imm};
  assign prod    = $signed({{DataWidth{Dest[Msb]}}, Dest}) * $signed({{DataWidth{Src[Msb]}}, Src});

  always_comb begin
    Result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    defined = 1'b1;
    case (Op)
      ADD: begin
        {carry, Result} = {1'b0, Dest} + {1'b0, Src};
        ovf = (Dest[Msb] == Src[Msb]) && (Result[Msb] != Dest[Msb]);
      end
      ADC: begin
        {carry, Result} = {1'b0, Dest} + {1'b0, Src} + {{DataWidth{1'b0}}, FlagsIn.Carry};
        ovf = (Dest[Msb] == Src[Msb]) && (Result[Msb] != Dest[Msb]);
      end
      SUB: begin
        {carry, Result} = {1'b0, Dest} - {1'b0, Src};
        ovf = (Dest[Msb] != Src[Msb]) && (Result[Msb] != Dest[Msb]);
      end
      ADDI: begin
        {carry, Result} = {1'b0, Dest} + {1'b0, imm_ext};
        ovf = (Dest[Msb] == imm_ext[Msb]) && (Result[Msb] != Dest[Msb]);
      end
      AND:  Result = Dest & Src;
      OR:   Result = Dest | Src;
      XOR:  Result = Dest ^ Src;
      NAND: Result = ~(Dest & Src);
      // Rotates act on Src through the carry flag.
      ROL:  {carry, Result} = {Src, FlagsIn.Carry};
      ROR:  {Result, carry} = {FlagsIn.Carry, Src};
      MUL:  Result = prod[DataWidth-1:0];
      MUH:  Result = prod[2*DataWidth-1:DataWidth];
      DIV:  Result = $signed(Dest) / $signed(Src);
      MOD:  Result = $signed(Dest) % $signed(Src);
      default: defined = 1'b0;
    endcase

    FlagsOut = FlagsIn;
    if (defined) begin
      FlagsOut.Carry    = carry;
      FlagsOut.Zero     = (Result == '0);
      FlagsOut.Negative = Result[Msb];
      FlagsOut.Overflow = ovf;
      FlagsOut.Parity   = ~^Result;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue ALU sequencer (IDLE -> EXEC -> [WAIT] -> DONE) holding one result until taken.
// Build option ALU_DIVZERO_TRAP_EN: DIV/MOD by zero skips WAIT, returns Dest and raises DivZero.
module alu_sequencer
  import InstructionSetPkg::*;
#(
  parameter int unsigned MultiCycleLatency = DefaultMultiCycleLatency
) (
  input  logic           Clock,
  input  logic           nReset,
  alu_sequencer_if.slave bus,
  output sFlags          Flags,
  input  logic           FlagsWrite,
  input  sFlags          FlagsIn,
  output logic           Busy
`ifdef ALU_DIVZERO_TRAP_EN
  ,
  output logic           DivZero
`endif
);

  localparam logic [3:0] LatencyLoad = 4'(MultiCycleLatency);

  eSeqState                  state;
  logic [3:0]                count;
  eOperation                 op_q;
  logic [ImmediateWidth-1:0] imm_q;
  logic [DataWidth-1:0]      src_q;
  logic [DataWidth-1:0]      dest_q;
  logic [DataWidth-1:0]      rsp_dest;
  logic [DataWidth-1:0]      alu_result;
  sFlags                     alu_flags;

`ifdef ALU_DIVZERO_TRAP_EN
  logic div_zero_q;
  logic div_trap;
  assign div_trap = ((op_q == DIV) || (op_q == MOD)) && (src_q == '0);
  assign DivZero  = div_zero_q;
`endif

  // The ALU reads the Flags register, so a FlagsWrite in the accept cycle is seen in EXEC.
  ArithmeticLogicUnit u_alu (
    .Op       (op_q),
    .Imm      (imm_q),
    .Src      (src_q),
    .Dest     (dest_q),
    .FlagsIn  (Flags),
    .Result   (alu_result),
    .FlagsOut (alu_flags)
  );

  assign bus.ReqReady = (state == IDLE);
  assign bus.RspValid = (state == DONE);
  assign bus.RspDest  = rsp_dest;
  assign Busy         = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= ADD;
      imm_q    <= '0;
      src_q    <= '0;
      dest_q   <= '0;
      rsp_dest <= '0;
      Flags    <= '0;
`ifdef ALU_DIVZERO_TRAP_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (FlagsWrite) Flags <= FlagsIn;
          if (bus.ReqValid) begin
            op_q   <= bus.ReqOp;
            imm_q  <= bus.ReqImm;
            src_q  <= bus.ReqSrc;
            dest_q <= bus.ReqDest;
            state  <= EXEC;
          end
        end
        EXEC: begin
`ifdef ALU_DIVZERO_TRAP_EN
          if (div_trap) begin
            rsp_dest   <= dest_q;
            div_zero_q <= 1'b1;
            state      <= DONE;
          end else
`endif
          if (IsMultiCycle(op_q)) begin
            count <= LatencyLoad;
            state <= WAIT;
          end else begin
            rsp_dest <= alu_result;
            Flags    <= alu_flags;
            state    <= DONE;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            rsp_dest <= alu_result;
            Flags    <= alu_flags;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.RspReady) begin
            state <= IDLE;
`ifdef ALU_DIVZERO_TRAP_EN
            div_zero_q <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: scoreboard of expected results, one task per scenario.
module tb_alu_sequencer;
  import InstructionSetPkg::*;

  localparam int unsigned Lat = 4;

  typedef struct packed {
    logic [15:0] dest;
    sFlags       flags;
  } exp_t;

  logic  Clock = 1'b0;
  logic  nReset;
  sFlags Flags;
  logic  FlagsWrite;
  sFlags FlagsIn;
  logic  Busy;
`ifdef ALU_DIVZERO_TRAP_EN
  logic  DivZero;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  alu_sequencer_if bus();

  alu_sequencer #(.MultiCycleLatency(Lat)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .bus        (bus),
    .Flags      (Flags),
    .FlagsWrite (FlagsWrite),
    .FlagsIn    (FlagsIn),
    .Busy       (Busy)
`ifdef ALU_DIVZERO_TRAP_EN
    ,
    .DivZero    (DivZero)
`endif
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic sFlags mk(input logic c, z, n, o, p);
    sFlags f;
    f.Carry = c; f.Zero = z; f.Negative = n; f.Overflow = o; f.Parity = p;
    return f;
  endfunction

  // Reference for ADD/SUB/XOR/ADDI using integer arithmetic.
  function automatic exp_t model(input eOperation op, input logic [7:0] imm,
                                 input logic [15:0] src, input logic [15:0] dest);
    exp_t m;
    int sa, sv, ua, uv, r;
    logic c, o;
    sa = int'($signed(dest));
    ua = int'(dest);
    if (op == ADDI) begin
      sv = int'($signed(imm));
      uv = sv & 32'h0000FFFF;
    end else begin
      sv = int'($signed(src));
      uv = int'(src);
    end
    c = 1'b0;
    o = 1'b0;
    case (op)
      ADD, ADDI: begin
        r = sa + sv;
        c = (ua + uv) > 65535;
        o = (r > 32767) || (r < -32768);
      end
      SUB: begin
        r = sa - sv;
        c = ua < uv;
        o = (r > 32767) || (r < -32768);
      end
      default: r = int'(dest ^ src);
    endcase
    m.dest  = r[15:0];
    m.flags = mk(c, m.dest == 16'h0000, m.dest[15], o, ($countones(m.dest) % 2) == 0);
    return m;
  endfunction

  task automatic issue(input eOperation op, input logic [7:0] imm, input logic [15:0] src,
                       input logic [15:0] dest, input logic fw, input sFlags fin);
    bus.ReqValid = 1'b1;
    bus.ReqOp    = op;
    bus.ReqImm   = imm;
    bus.ReqSrc   = src;
    bus.ReqDest  = dest;
    FlagsWrite   = fw;
    FlagsIn      = fin;
    @(negedge Clock);
    bus.ReqValid = 1'b0;
    FlagsWrite   = 1'b0;
    FlagsIn      = '0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 1;
    while (bus.RspValid !== 1'b1 && cycles < 40) begin
      @(negedge Clock);
      cycles++;
    end
  endtask

  task automatic ack();
    bus.RspReady = 1'b1;
    @(negedge Clock);
    bus.RspReady = 1'b0;
  endtask

  task automatic preload(input sFlags f);
    FlagsIn    = f;
    FlagsWrite = 1'b1;
    @(negedge Clock);
    FlagsWrite = 1'b0;
    FlagsIn    = '0;
  endtask

  task automatic test_reset();
    nReset       = 1'b0;
    FlagsWrite   = 1'b1;
    FlagsIn      = '1;
    bus.ReqValid = 1'b1;
    repeat (2) @(negedge Clock);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (bus.RspValid !== 1'b0) begin errors++; $display("FAIL reset_rspvalid: got %b expected 0", bus.RspValid); end
    checks++; if (bus.RspDest !== 16'h0000) begin errors++; $display("FAIL reset_rspdest: got %h expected 0000", bus.RspDest); end
    checks++; if (Flags !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b expected 00000", Flags); end
    checks++; if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL reset_reqready: got %b expected 1", bus.ReqReady); end
    nReset       = 1'b1;
    FlagsWrite   = 1'b0;
    FlagsIn      = '0;
    bus.ReqValid = 1'b0;
    @(negedge Clock);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", Busy); end
    checks++; if (Flags !== 5'b00000) begin errors++; $display("FAIL reset_release_flags: got %b expected 00000", Flags); end
  endtask

  task automatic test_adc();
    int c;
    exp_t e;
    preload(mk(1, 0, 0, 0, 0));
    checks++; if (Flags !== mk(1, 0, 0, 0, 0)) begin errors++; $display("FAIL adc_preload: got %b expected 10000", Flags); end
    e.dest = 16'd8; e.flags = mk(0, 0, 0, 0, 0);
    sb.push_back(e);
    issue(ADC, 8'h00, 16'd3, 16'd4, 1'b0, '0);
    checks++; if (bus.ReqReady !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL adc_exec_state: got ready %b busy %b expected ready 0 busy 1", bus.ReqReady, Busy); end
    wait_rsp(c);
    checks++; if (c != 2) begin errors++; $display("FAIL adc_latency: got %0d expected 2", c); end
    e = sb.pop_front();
    checks++; if (bus.RspDest !== e.dest) begin errors++; $display("FAIL adc_dest: got %h expected %h", bus.RspDest, e.dest); end
    checks++; if (Flags !== e.flags) begin errors++; $display("FAIL adc_flags: got %b expected %b", Flags, e.flags); end
    ack();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL adc_idle_after_ack: got %b expected 0", Busy); end
  endtask

  task automatic test_mul();
    int c;
    logic busy_ok;
    exp_t e;
    e.dest = 16'hFFF1; e.flags = mk(0, 0, 1, 0, 0);
    sb.push_back(e);
    issue(MUL, 8'h00, 16'd5, 16'hFFFD, 1'b0, '0);
    busy_ok    = 1'b1;
    c          = 1;
    FlagsWrite = 1'b1;
    FlagsIn    = '1;
    while (bus.RspValid !== 1'b1 && c < 40) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (c == 3) begin
        FlagsWrite = 1'b0;
        FlagsIn    = '0;
        checks++; if (Flags !== 5'b00000) begin errors++; $display("FAIL mul_flagswrite_ignored: got %b expected 00000", Flags); end
      end
      @(negedge Clock);
      c++;
    end
    FlagsWrite = 1'b0;
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL mul_busy: got low expected high throughout"); end
    checks++; if (c != 2 + Lat) begin errors++; $display("FAIL mul_latency: got %0d expected %0d", c, 2 + Lat); end
    e = sb.pop_front();
    checks++; if (bus.RspDest !== e.dest) begin errors++; $display("FAIL mul_dest: got %h expected %h", bus.RspDest, e.dest); end
    checks++; if (Flags.Negative !== 1'b1) begin errors++; $display("FAIL mul_negative: got %b expected 1", Flags.Negative); end
    checks++; if (Flags !== e.flags) begin errors++; $display("FAIL mul_flags: got %b expected %b", Flags, e.flags); end
    ack();
  endtask

  task automatic test_rol();
    int c;
    exp_t e;
    e.dest = 16'h0001; e.flags = mk(0, 0, 0, 0, 0);
    sb.push_back(e);
    issue(ROL, 8'h00, 16'h0000, 16'h1234, 1'b1, mk(1, 0, 0, 0, 0));
    wait_rsp(c);
    checks++; if (c != 2) begin errors++; $display("FAIL rol_latency: got %0d expected 2", c); end
    e = sb.pop_front();
    checks++; if (bus.RspDest !== e.dest) begin errors++; $display("FAIL rol_dest: got %h expected %h", bus.RspDest, e.dest); end
    checks++; if (Flags.Carry !== 1'b0) begin errors++; $display("FAIL rol_carry: got %b expected 0", Flags.Carry); end
    checks++; if (Flags !== e.flags) begin errors++; $display("FAIL rol_flags: got %b expected %b", Flags, e.flags); end
    ack();
  endtask

  task automatic test_hold();
    int c;
    logic hold_ok;
    exp_t e;
    e.dest = 16'h0FFF; e.flags = mk(0, 0, 0, 0, 1);
    sb.push_back(e);
    issue(NAND, 8'h00, 16'hFF00, 16'hF0F0, 1'b0, '0);
    wait_rsp(c);
    checks++; if (c != 2) begin errors++; $display("FAIL hold_latency: got %0d expected 2", c); end
    e = sb.pop_front();
    hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ReqValid = 1'b1;
      bus.ReqOp    = ADD;
      bus.ReqSrc   = 16'h0001;
      bus.ReqDest  = 16'h0001;
      FlagsWrite   = 1'b1;
      FlagsIn      = '1;
      @(negedge Clock);
      if (bus.RspDest !== e.dest || Flags !== e.flags || bus.RspValid !== 1'b1 || bus.ReqReady !== 1'b0)
        hold_ok = 1'b0;
    end
    FlagsWrite = 1'b0;
    FlagsIn    = '0;
    checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL hold_stable: got dest %h flags %b expected %h %b held", bus.RspDest, Flags, e.dest, e.flags); end
    checks++; if (bus.RspDest !== e.dest) begin errors++; $display("FAIL hold_dest: got %h expected %h", bus.RspDest, e.dest); end
    checks++; if (Flags !== e.flags) begin errors++; $display("FAIL hold_flags: got %b expected %b", Flags, e.flags); end
    // ReqValid stays high across the handshake edge; it must not be taken there.
    bus.RspReady = 1'b1;
    @(negedge Clock);
    bus.RspReady = 1'b0;
    bus.ReqValid = 1'b0;
    checks++; if (Busy !== 1'b0 || bus.RspValid !== 1'b0) begin errors++; $display("FAIL hold_release: got busy %b rspvalid %b expected 0 0", Busy, bus.RspValid); end
    checks++; if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL hold_reqready: got %b expected 1", bus.ReqReady); end
    @(negedge Clock);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL hold_no_accept: got %b expected 0", Busy); end
    checks++; if (Flags !== e.flags) begin errors++; $display("FAIL hold_flags_after: got %b expected %b", Flags, e.flags); end
  endtask

  task automatic test_multicycle_ops();
    eOperation   ops[3]  = '{MUH, DIV, MOD};
    logic [15:0] srcs[3] = '{16'd5, 16'd2, 16'd2};
    logic [15:0] dsts[3] = '{16'hFFFD, 16'hFFF9, 16'hFFF9};
    logic [15:0] res[3]  = '{16'hFFFF, 16'hFFFD, 16'hFFFF};
    sFlags       fl[3];
    int c;
    exp_t e;
    fl[0] = mk(0, 0, 1, 0, 1);
    fl[1] = mk(0, 0, 1, 0, 0);
    fl[2] = mk(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      e.dest = res[i]; e.flags = fl[i];
      sb.push_back(e);
      issue(ops[i], 8'h00, srcs[i], dsts[i], 1'b0, '0);
      wait_rsp(c);
      checks++; if (c != 2 + Lat) begin errors++; $display("FAIL mc_latency[%0d]: got %0d expected %0d", i, c, 2 + Lat); end
      e = sb.pop_front();
      checks++; if (bus.RspDest !== e.dest) begin errors++; $display("FAIL mc_dest[%0d]: got %h expected %h", i, bus.RspDest, e.dest); end
      checks++; if (Flags !== e.flags) begin errors++; $display("FAIL mc_flags[%0d]: got %b expected %b", i, Flags, e.flags); end
      ack();
    end
  endtask

  task automatic test_undef();
    int c;
    exp_t e;
    preload(mk(0, 1, 0, 1, 0));
    e.dest = 16'h0000; e.flags = mk(0, 1, 0, 1, 0);
    sb.push_back(e);
    issue(eOperation'(4'hF), 8'h55, 16'h1234, 16'h5678, 1'b0, '0);
    wait_rsp(c);
    checks++; if (c != 2) begin errors++; $display("FAIL undef_latency: got %0d expected 2", c); end
    e = sb.pop_front();
    checks++; if (bus.RspDest !== e.dest) begin errors++; $display("FAIL undef_dest: got %h expected %h", bus.RspDest, e.dest); end
    checks++; if (Flags !== e.flags) begin errors++; $display("FAIL undef_flags: got %b expected %b", Flags, e.flags); end
    ack();
  endtask

  task automatic test_back_to_back();
    int c;
    exp_t e;
    eOperation op;
    logic [15:0] src, dest;
    logic [7:0] imm;
    bus.RspReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src  = 16'($urandom);
      dest = 16'($urandom);
      imm  = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       op = ADD;
        1:       op = SUB;
        2:       op = XOR;
        default: op = ADDI;
      endcase
      if (i == 0) begin op = ADD; src = 16'h0001; dest = 16'h7FFF; end
      if (i == 1) begin op = SUB; src = 16'h0001; dest = 16'h0000; end
      if (i == 2) begin op = ADDI; imm = 8'hFF; dest = 16'h0001; end
      sb.push_back(model(op, imm, src, dest));
      issue(op, imm, src, dest, 1'b0, '0);
      wait_rsp(c);
      checks++; if (c != 2) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 2", i, c); end
      e = sb.pop_front();
      checks++; if (bus.RspDest !== e.dest) begin errors++; $display("FAIL b2b_dest[%0d] op %0d: got %h expected %h", i, op, bus.RspDest, e.dest); end
      checks++; if (Flags !== e.flags) begin errors++; $display("FAIL b2b_flags[%0d] op %0d: got %b expected %b", i, op, Flags, e.flags); end
      @(negedge Clock);
    end
    bus.RspReady = 1'b0;
  endtask

  task automatic test_reset_div();
    logic seen;
    preload('1);
    issue(DIV, 8'h00, 16'd7, 16'd100, 1'b0, '0);
    @(negedge Clock);
    nReset = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    checks++; if (Busy !== 1'b0 || bus.RspValid !== 1'b0) begin errors++; $display("FAIL rstdiv_state: got busy %b rspvalid %b expected 0 0", Busy, bus.RspValid); end
    checks++; if (Flags !== 5'b00000) begin errors++; $display("FAIL rstdiv_flags: got %b expected 00000", Flags); end
    seen = 1'b0;
    repeat (Lat + 6) begin
      @(negedge Clock);
      if (bus.RspValid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstdiv_no_response: got response expected none"); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstdiv_idle: got %b expected 0", Busy); end
  endtask

`ifdef ALU_DIVZERO_TRAP_EN
  task automatic test_divzero();
    int c;
    exp_t e;
    preload(mk(1, 0, 0, 1, 1));
    e.dest = 16'd7; e.flags = mk(1, 0, 0, 1, 1);
    sb.push_back(e);
    issue(DIV, 8'h00, 16'd0, 16'd7, 1'b0, '0);
    wait_rsp(c);
    checks++; if (c != 2) begin errors++; $display("FAIL divzero_latency: got %0d expected 2", c); end
    e = sb.pop_front();
    checks++; if (bus.RspDest !== e.dest) begin errors++; $display("FAIL divzero_dest: got %h expected %h", bus.RspDest, e.dest); end
    checks++; if (Flags !== e.flags) begin errors++; $display("FAIL divzero_flags: got %b expected %b", Flags, e.flags); end
    checks++; if (DivZero !== 1'b1) begin errors++; $display("FAIL divzero_flag: got %b expected 1", DivZero); end
    ack();
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL divzero_clear: got %b expected 0", DivZero); end
  endtask
`endif

  initial begin
    bus.ReqValid = 1'b0;
    bus.ReqOp    = ADD;
    bus.ReqImm   = '0;
    bus.ReqSrc   = '0;
    bus.ReqDest  = '0;
    bus.RspReady = 1'b0;
    FlagsWrite   = 1'b0;
    FlagsIn      = '0;
    nReset       = 1'b0;
    test_reset();
    test_adc();
    test_mul();
    test_rol();
    test_hold();
    test_multicycle_ops();
    test_undef();
    test_back_to_back();
`ifdef ALU_DIVZERO_TRAP_EN
    test_divzero();
`endif
    test_reset_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MultiCycleLatency, default 4: extra cycles spent in WAIT by MUL, MUH, DIV, MOD; legal range 1..15.
REQ-002 SHALL have ports:
- Clock  in  1  sole clock; all state changes on its rising edge.
- nReset  in  1  reset, synchronous and active-low.
- ReqValid  in  1  request present.
- ReqReady  out  1  sequencer can accept.
- ReqOp  in  eOperation  operation.
- ReqImm  in  ImmediateWidth  immediate.
- ReqSrc  in  DataWidth  source register value.
- ReqDest  in  DataWidth  destination register value.
- RspValid  out  1  result available.
- RspReady  in  1  consumer takes result.
- RspDest  out  DataWidth  result for destination register.
- Flags  out  sFlags  architectural flags register.
- FlagsWrite  in  1  load Flags from FlagsIn.
- FlagsIn  in  sFlags  external flags value.
- Busy  out  1  state is not IDLE.
- DivZero  out  1  divide-by-zero indication; present only with ALU_DIVZERO_TRAP_EN.

Function
REQ-003 SHALL implement states IDLE, EXEC, WAIT, DONE; ReqReady = 1 only in IDLE.
REQ-004 IDLE: on ReqValid&&ReqReady SHALL latch ReqOp/ReqImm/ReqSrc/ReqDest and go to EXEC; otherwise stay.
REQ-005 EXEC: ALU evaluated on latched operands and current Flags; single-cycle ops SHALL capture RspDest and Flags from ALU outputs and go to DONE.
REQ-006 EXEC: MUL/MUH/DIV/MOD SHALL load a down-counter with MultiCycleLatency and go to WAIT.
REQ-007 WAIT: counter decrements each cycle; on the cycle it equals 1, SHALL capture RspDest and Flags and go to DONE.
REQ-008 Latency: single-cycle op accepted at edge k SHALL show RspValid=1 after edge k+2; multi-cycle op after edge k+2+MultiCycleLatency.
REQ-009 DONE: RspValid=1; RspDest, Flags SHALL remain stable until RspValid&&RspReady, then go to IDLE (RspValid=0 next cycle).
REQ-010 No new request accepted in the same cycle as response handshake; at most one instruction in flight.
REQ-011 Undefined opcode SHALL complete as single-cycle with RspDest=0 and Flags unchanged.
REQ-012 FlagsWrite SHALL load Flags only in IDLE; ignored in EXEC/WAIT/DONE.
REQ-013 FlagsWrite coincident with acceptance SHALL load FlagsIn, and the accepted instruction SHALL use the loaded value.
REQ-014 ReqValid while not IDLE SHALL be ignored without side effects.

Reset
REQ-015 nReset low at a rising edge SHALL force IDLE, RspValid=0, RspDest=0, Flags=0, counter=0, DivZero=0, Busy=0, abandoning any in-flight instruction.
REQ-016 Reset SHALL take priority over FlagsWrite and request acceptance in the same cycle.

Configuration
REQ-017 With ALU_DIVZERO_TRAP_EN defined, DIV/MOD with latched Src=0 SHALL skip WAIT, reach DONE per single-cycle latency with RspDest=latched Dest, Flags unchanged, DivZero=1 while in DONE.
REQ-018 Without ALU_DIVZERO_TRAP_EN, the DivZero port and detection logic SHALL be absent; DIV/MOD by zero follows REQ-006/007 with RspDest unspecified.

Structure
REQ-019 eSeqState enum and a MultiCycleLatency default constant SHALL live in InstructionSetPkg alongside eOperation, sFlags, DataWidth, ImmediateWidth.
REQ-020 SHALL instantiate ArithmeticLogicUnit as its single sub-module, fed from latched operands and the Flags register.

Verification
REQ-021 ADC Src=3, Dest=4, Flags.Carry=1 preloaded via FlagsWrite -> RspDest=8, Carry=0, Zero=0, Negative=0, Overflow=0, Parity=0; RspValid 2 cycles after accept.
REQ-022 MUL Dest=-3, Src=5, MultiCycleLatency=4 -> RspDest=-15, Negative=1; RspValid 6 cycles after accept; Busy high throughout.
REQ-023 ROL Src=0 with FlagsWrite Carry=1 in accept cycle -> RspDest=1, Carry=0.
REQ-024 NAND result held with RspReady low 3 cycles -> RspDest/Flags stable, ReqReady=0, second ReqValid ignored; IDLE 1 cycle after RspReady.
REQ-025 nReset low during WAIT of DIV -> next cycle IDLE, RspValid=0, Flags=0, no response ever issued for that DIV.
REQ-026 ALU_DIVZERO_TRAP_EN: DIV Dest=7, Src=0 -> RspDest=7, DivZero=1, Flags unchanged, RspValid 2 cycles after accept.
